ddr_tx_serializer: RTL
======================

DDR_TX_SERIALIZER -- requirements
Module: ddr_tx_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of output lanes.
REQ-002 SHALL have parameter RATIO, default 8: bits per lane per word; even, at least 2.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = lane MSB transmitted first, 0 = LSB first.
REQ-004 SHALL have parameter IDLE, default 0: 1-bit level driven on every lane when no data is transmitted.
REQ-005 SHALL have port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: clock enable; when 0, all state is frozen.
REQ-008 SHALL have port in_data, input, WIDTH*RATIO bits: lane i occupies in_data[i*RATIO +: RATIO].
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: a word is accepted on an edge where in_valid, in_ready and enable are all 1.
REQ-011 SHALL have port d1, output, WIDTH bits: rising-half bit per lane, intended for the downstream DDR output register D1 input.
REQ-012 SHALL have port d2, output, WIDTH bits: falling-half bit per lane, intended for the D2 input.
REQ-013 SHALL have port busy, output, 1 bit: a word is in transmission or pending.
REQ-014 SHALL have port burst_end, output, 1 bit: one-cycle pulse marking a return to idle.

Function
REQ-015 SHALL hold two word slots: a shift stage (active word) and a holding slot (pending word).
REQ-016 SHALL transmit each word as RATIO/2 beats, one beat per enabled cycle; beat k drives, per lane, d1 = bit RATIO-1-2k and d2 = bit RATIO-2-2k when MSB_FIRST=1, or d1 = bit 2k and d2 = bit 2k+1 when MSB_FIRST=0.
REQ-017 SHALL register d1, d2, busy and burst_end; none of them may depend combinationally on any input.
REQ-018 SHALL drive in_ready = enable AND NOT reset AND (holding slot empty OR holding slot moves to the shift stage on this edge); in_ready SHALL NOT depend on in_valid.
REQ-019 SHALL move the holding slot to the shift stage on an edge where the shift stage is empty or issuing its last beat; a word accepted while both slots are empty SHALL bypass directly into the shift stage.
REQ-020 SHALL present beat 0 of a word accepted at edge N into an empty block on d1/d2 from edge N+1; beat k is presented from edge N+1+k.
REQ-021 SHALL stream back-to-back with no idle beat whenever the next word is accepted no later than the edge registering the previous word's last beat; RATIO=2 SHALL sustain one word per cycle.
REQ-022 SHALL drive d1 = d2 = {WIDTH{IDLE}} on every cycle with no beat to present.
REQ-023 SHALL assert burst_end for exactly one cycle, registered on the edge where the outputs change from the last beat of a word to idle.
REQ-024 SHALL drive busy = 1 when either slot is occupied.
REQ-025 SHALL, with enable = 0, hold all registers including d1, d2 and busy, accept nothing, and extend burst_end for as long as the stall lasts.
REQ-026 SHALL use an internal beat counter of width clog2(RATIO/2), minimum 1, that wraps from RATIO/2-1 to 0.

Reset
REQ-027 SHALL, on an edge with reset = 1, regardless of enable: empty both slots, clear the beat counter, set d1 = d2 = {WIDTH{IDLE}}, set busy = 0 and set burst_end = 0.
REQ-028 SHALL keep in_ready = 0 while reset = 1; a reset asserted mid-word SHALL discard the remaining beats and any pending word, with no burst_end pulse.
REQ-029 SHALL leave d1/d2 at the IDLE level on the first cycle after reset deasserts.

Verification (WIDTH=2, RATIO=8, MSB_FIRST=1, IDLE=0 unless stated)
REQ-030 Single word: in_data=16'hA5_3C accepted at edge N -> lane 0 (8'h3C): d1/d2 = 0/0, 1/1, 1/1, 0/0; lane 1 (8'hA5): 1/0, 1/0, 0/1, 0/1; on edges N+1 to N+4, then idle; burst_end=1 for one cycle only, after edge N+5.
REQ-031 Back-to-back: 3 words with in_valid held high -> 12 consecutive beats with no idle gap; in_ready low while both slots are full; exactly one burst_end, after the last beat.
REQ-032 RATIO=2, in_valid held high for 10 cycles -> in_ready stays 1, 10 consecutive one-beat words, d1/d2 equal to each word's bits 1/0.
REQ-033 enable low for 3 cycles in mid-beat 2 -> d1/d2 frozen on beat 2 for 3 extra cycles, no word accepted, then beats 3 onward resume unchanged.
REQ-034 Reset mid-word (after beat 1) with a word pending -> after the reset edge d1=d2=0, busy=0, no burst_end, and the pending word is never transmitted.
REQ-035 MSB_FIRST=0, IDLE=1, lane word 8'h01 -> d1/d2 = 1/0, 0/0, 0/0, 0/0, then 1/1 while idle.

Source files
------------

// File: rtl/ddr_tx_serializer.sv
// ddr_tx_serializer
//   Splits WIDTH*RATIO-bit words into RATIO/2 DDR beats per lane. Each beat
//   carries a rising-half bit (d1) and a falling-half bit (d2) for every lane.
//   These bits feed an external DDR output register. Two word slots let the
//   next word wait while the current one is shifted out, so streaming has no gaps.
//
// Ports
//   clock      : the only clock; all state updates on its rising edge
//   reset      : synchronous, active-high
//   enable     : clock enable; when 0 every register holds
//   in_data    : lane i occupies in_data[i*RATIO +: RATIO]
//   in_valid   : in_data is valid
//   in_ready   : word accepted when in_valid & in_ready & enable
//   d1 / d2    : registered rising-/falling-half bit per lane
//   busy       : registered, 1 while either word slot is occupied
//   burst_end  : registered one-cycle pulse on the return to idle

// Per-lane beat extraction: picks the two bits of the current beat and
// produces the lane word shifted by one beat.
module ddr_tx_serializer_lane #(
  parameter int RATIO     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [RATIO-1:0] i_word,
  output logic             o_d1,
  output logic             o_d2,
  output logic [RATIO-1:0] o_next
);
  generate
    if (MSB_FIRST) begin : g_msb
      assign o_d1   = i_word[RATIO-1];
      assign o_d2   = i_word[RATIO-2];
      assign o_next = i_word << 2;
    end else begin : g_lsb
      assign o_d1   = i_word[0];
      assign o_d2   = i_word[1];
      assign o_next = i_word >> 2;
    end
  endgenerate
endmodule

module ddr_tx_serializer #(
  parameter int WIDTH     = 4,
  parameter int RATIO     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE      = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WIDTH*RATIO-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       d1,
  output logic [WIDTH-1:0]       d2,
  output logic                   busy,
  output logic                   burst_end
);
  localparam int            DW    = WIDTH * RATIO;
  localparam int            BEATS = RATIO / 2;
  localparam int            BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST  = BW'(BEATS - 1);

  // Shift stage (active word) and holding slot (pending word)
  logic [DW-1:0]    r_sh_data;
  logic             r_sh_vld;
  logic [DW-1:0]    r_hd_data;
  logic             r_hd_vld;
  logic [BW-1:0]    r_beat;
  logic [WIDTH-1:0] r_d1;
  logic [WIDTH-1:0] r_d2;
  logic             r_busy;
  logic             r_burst_end;
  logic             r_out_last;   // d1/d2 currently show a word's last beat

  logic [WIDTH-1:0] w_d1;
  logic [WIDTH-1:0] w_d2;
  logic [DW-1:0]    w_shift;
  logic             w_last;
  logic             w_sh_free;
  logic             w_move;
  logic             w_bypass;
  logic             w_acc;
  logic             w_to_hold;
  logic             w_sh_vld_nxt;
  logic             w_hd_vld_nxt;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      ddr_tx_serializer_lane #(
        .RATIO     (RATIO),
        .MSB_FIRST (MSB_FIRST)
      ) u_lane (
        .i_word (r_sh_data[gi*RATIO +: RATIO]),
        .o_d1   (w_d1[gi]),
        .o_d2   (w_d2[gi]),
        .o_next (w_shift[gi*RATIO +: RATIO])
      );
    end
  endgenerate

  // The shift stage can take a new word when it is empty or issuing its
  // last beat on this edge.
  assign w_last    = r_sh_vld && (r_beat == LAST);
  assign w_sh_free = !r_sh_vld || w_last;
  assign w_move    = r_hd_vld && w_sh_free;
  // With the holding slot empty, an accepted word goes straight into a
  // freeing shift stage. This keeps back-to-back words gapless, including RATIO=2.
  assign w_bypass  = !r_hd_vld && w_sh_free;

  assign in_ready  = enable && !reset && (!r_hd_vld || w_move);
  assign w_acc     = in_valid && in_ready;
  assign w_to_hold = w_acc && !w_bypass;

  assign w_sh_vld_nxt = !w_sh_free || r_hd_vld || w_acc;
  assign w_hd_vld_nxt = w_to_hold || (r_hd_vld && !w_move);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sh_data   <= '0;
      r_sh_vld    <= 1'b0;
      r_hd_data   <= '0;
      r_hd_vld    <= 1'b0;
      r_beat      <= '0;
      r_d1        <= {WIDTH{IDLE}};
      r_d2        <= {WIDTH{IDLE}};
      r_busy      <= 1'b0;
      r_burst_end <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (enable) begin
      if (w_sh_free) begin
        r_beat <= '0;
        if (r_hd_vld)   r_sh_data <= r_hd_data;
        else if (w_acc) r_sh_data <= in_data;
      end else begin
        r_sh_data <= w_shift;
        r_beat    <= r_beat + 1'b1;
      end
      r_sh_vld <= w_sh_vld_nxt;

      if (w_to_hold) r_hd_data <= in_data;
      r_hd_vld <= w_hd_vld_nxt;

      if (r_sh_vld) begin
        r_d1 <= w_d1;
        r_d2 <= w_d2;
      end else begin
        r_d1 <= {WIDTH{IDLE}};
        r_d2 <= {WIDTH{IDLE}};
      end
      r_out_last  <= w_last;
      // Last beat showing and nothing follows: outputs drop to idle now
      r_burst_end <= r_out_last && !r_sh_vld;
      r_busy      <= w_sh_vld_nxt || w_hd_vld_nxt;
    end
  end

  assign d1        = r_d1;
  assign d2        = r_d2;
  assign busy      = r_busy;
  assign burst_end = r_burst_end;
endmodule
